// File: rtl/cordic_ctrl_pkg.sv
// cordic_ctrl_pkg: shared types and helpers for the CORDIC controller.
// Holds the FSM state enum and the hyperbolic repeat schedule.
package cordic_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_e;

  // Hyperbolic shifts issued twice to keep the series convergent
  localparam int unsigned HYP_REP_0 = 4;
  localparam int unsigned HYP_REP_1 = 13;
  localparam int unsigned HYP_REP_2 = 40;

  function automatic int iter_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

  function automatic logic is_hyp_repeat(input int unsigned s);
    return s == HYP_REP_0 || s == HYP_REP_1 || s == HYP_REP_2;
  endfunction

endpackage

// File: rtl/cordic_shift_gen.sv
// cordic_shift_gen: per-step shift index for the CORDIC core.
// Circular counts from 0; hyperbolic from 1 with repeated indices.
module cordic_shift_gen
  import cordic_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       system_i,
  input  logic       start_i,
  input  logic       advance_i,
  output logic [4:0] shift_o
);

  logic [4:0] shift_q, shift_d;
  logic       rep_q, rep_d;
  logic       hold;

  assign hold = !system_i && !rep_q
             && is_hyp_repeat(32'(shift_q));

  always_comb begin
    shift_d = shift_q;
    rep_d   = rep_q;
    unique case (1'b1)
      start_i: begin
        shift_d = system_i ? 5'd0 : 5'd1;
        rep_d   = 1'b0;
      end
      advance_i && hold: rep_d = 1'b1;
      advance_i && !hold: begin
        shift_d = shift_q + 5'd1;
        rep_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rep_q   <= rep_d;
    end
  end

  assign shift_o = shift_q;

endmodule

// File: rtl/cordic_controller.sv
// cordic_controller: sequences one CORDIC operation through the core:
// load, n shifted steps with overflow abort, then a held response.
module cordic_controller
  import cordic_ctrl_pkg::*;
#(
  parameter int p_WIDTH    = 32,
  parameter int p_MAX_ITER = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [p_WIDTH-1:0]            req_x,
  input  logic [p_WIDTH-1:0]            req_y,
  input  logic [p_WIDTH-1:0]            req_z,
  input  logic                          req_system,
  input  logic                          req_mode,
  input  logic [iter_w(p_MAX_ITER)-1:0] req_num_iter,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [p_WIDTH-1:0]            rsp_x,
  output logic [p_WIDTH-1:0]            rsp_y,
  output logic [p_WIDTH-1:0]            rsp_z,
  output logic                          rsp_overflow,
  output logic [iter_w(p_MAX_ITER)-1:0] rsp_iter,
  output logic                          busy,
  output logic                          core_load,
  output logic [p_WIDTH-1:0]            core_x_in,
  output logic [p_WIDTH-1:0]            core_y_in,
  output logic [p_WIDTH-1:0]            core_z_in,
  output logic                          core_system,
  output logic                          core_mode,
  output logic                          core_step,
  output logic [4:0]                    core_shift,
  input  logic [p_WIDTH-1:0]            core_x_out,
  input  logic [p_WIDTH-1:0]            core_y_out,
  input  logic [p_WIDTH-1:0]            core_z_out,
  input  logic                          core_overflow
);

  localparam int NW = iter_w(p_MAX_ITER);
  localparam logic [NW-1:0] MAXN = NW'(p_MAX_ITER);

  state_e              state_q, state_d;
  logic [p_WIDTH-1:0]  x_q, y_q, z_q;
  logic [p_WIDTH-1:0]  rx_q, ry_q, rz_q;
  logic                sys_q, mode_q;
  logic [NW-1:0]       n_q, cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                stepped_q, first_q;
  logic                accept, ovf_now, in_done;
  logic [4:0]          shift;

  assign accept  = req_valid && state_q == S_IDLE;
  assign ovf_now = stepped_q && core_overflow;
  assign in_done = state_q == S_DONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) state_d = S_LOAD;
      S_LOAD: begin
        core_load = 1'b1;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = (n_q == '0) ? S_DONE : S_ITER;
      end
      S_ITER: begin
        if (ovf_now) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_d == n_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // overflow on the final step is only visible here
        ovf_d = ovf_q | ovf_now;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      sys_q     <= 1'b0;
      mode_q    <= 1'b0;
      n_q       <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      stepped_q <= 1'b0;
      first_q   <= 1'b0;
      rx_q      <= '0;
      ry_q      <= '0;
      rz_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      stepped_q <= core_step;
      first_q   <= state_d == S_DONE && state_q != S_DONE;
      if (accept) begin
        x_q    <= req_x;
        y_q    <= req_y;
        z_q    <= req_z;
        sys_q  <= req_system;
        mode_q <= req_mode;
        n_q    <= (req_num_iter > MAXN) ? MAXN : req_num_iter;
      end
      if (first_q) begin
        rx_q <= core_x_out;
        ry_q <= core_y_out;
        rz_q <= core_z_out;
      end
    end
  end

  cordic_shift_gen u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .system_i  (sys_q),
    .start_i   (state_q == S_LOAD),
    .advance_i (core_step),
    .shift_o   (shift)
  );

  assign req_ready    = state_q == S_IDLE;
  assign busy         = state_q != S_IDLE;
  assign rsp_valid    = in_done;
  // core outputs settle on DONE entry; registered copies hold afterwards
  assign rsp_x        = !in_done ? '0 : first_q ? core_x_out : rx_q;
  assign rsp_y        = !in_done ? '0 : first_q ? core_y_out : ry_q;
  assign rsp_z        = !in_done ? '0 : first_q ? core_z_out : rz_q;
  assign rsp_overflow = in_done && (ovf_q || ovf_now);
  assign rsp_iter     = in_done ? cnt_q : '0;
  assign core_x_in    = x_q;
  assign core_y_in    = y_q;
  assign core_z_in    = z_q;
  assign core_system  = sys_q;
  assign core_mode    = mode_q;
  assign core_shift   = core_step ? shift : '0;

endmodule

// File: tb/tb_cordic_controller.sv
// tb_cordic_controller: scoreboard bench with a behavioural CORDIC core
// and an injectable overflow, checking sequencing, timing and results.
module tb_cordic_controller;

  localparam int  W  = 32;
  localparam int  MI = 24;
  localparam int  NW = 5;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    logic signed [W-1:0] x, y, z;
    int iter;
    bit ovf;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [W-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic req_system = 1'b0, req_mode = 1'b0;
  logic [NW-1:0] req_num_iter = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [W-1:0] rsp_x, rsp_y, rsp_z;
  logic rsp_overflow;
  logic [NW-1:0] rsp_iter;
  logic busy, core_load, core_system, core_mode, core_step;
  logic [W-1:0] core_x_in, core_y_in, core_z_in;
  logic [4:0] core_shift;
  logic signed [W-1:0] cx = '0, cy = '0, cz = '0;
  logic c_ovf = 1'b0;
  int c_steps = 0;
  int ovf_at = 0;

  int n_vec = 0;
  int n_err = 0;
  longint cyc = 0;
  exp_t sb[$];
  int shq[$];
  int hyp_seq[$];
  logic cur_sys = 1'b0, cur_mode = 1'b0;

  cordic_controller #(.p_WIDTH(W), .p_MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_system(req_system), .req_mode(req_mode),
    .req_num_iter(req_num_iter),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .rsp_overflow(rsp_overflow), .rsp_iter(rsp_iter),
    .busy(busy), .core_load(core_load),
    .core_x_in(core_x_in), .core_y_in(core_y_in), .core_z_in(core_z_in),
    .core_system(core_system), .core_mode(core_mode),
    .core_step(core_step), .core_shift(core_shift),
    .core_x_out(cx), .core_y_out(cy), .core_z_out(cz),
    .core_overflow(c_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [W-1:0] ang(input logic sys, input int i);
    real r;
    if (!sys && i == 0) return '0;
    r = sys ? $atan(2.0 ** (-i)) : $atanh(2.0 ** (-i));
    return $rtoi(r / (2.0 * PI) * 4294967296.0);
  endfunction

  function automatic void cstep(input logic sys, input logic mode,
                                input int sh,
                                inout logic signed [W-1:0] x,
                                inout logic signed [W-1:0] y,
                                inout logic signed [W-1:0] z);
    logic signed [W-1:0] xs, ys, a, nx;
    bit pos;
    xs  = x >>> sh;
    ys  = y >>> sh;
    a   = ang(sys, sh);
    pos = mode ? (z >= 0) : (y < 0);
    if (pos) begin
      nx = sys ? x - ys : x + ys;
      y  = y + xs;
      z  = z - a;
    end else begin
      nx = sys ? x + ys : x - ys;
      y  = y - xs;
      z  = z + a;
    end
    x = nx;
  endfunction

  // behavioural core: state valid the cycle after load/step
  logic signed [W-1:0] tx, ty, tz;
  always @(posedge clk) begin
    if (core_load) begin
      cx <= core_x_in;
      cy <= core_y_in;
      cz <= core_z_in;
      c_ovf <= 1'b0;
      c_steps <= 0;
    end else if (core_step) begin
      tx = cx; ty = cy; tz = cz;
      cstep(core_system, core_mode, int'(core_shift), tx, ty, tz);
      cx <= tx; cy <= ty; cz <= tz;
      c_steps <= c_steps + 1;
      c_ovf <= (c_steps + 1 == ovf_at);
    end
  end

  always @(negedge clk) begin
    if (rst_n && (core_load || core_step))
      chk("load_step_excl", core_load && core_step, 0);
    if (core_step) begin
      shq.push_back(int'(core_shift));
      chk("sys_hold", core_system, cur_sys);
      chk("mode_hold", core_mode, cur_mode);
    end
  end

  function automatic exp_t ref_run(input logic sys, input logic mode,
                                   input logic signed [W-1:0] x0,
                                   input logic signed [W-1:0] y0,
                                   input logic signed [W-1:0] z0,
                                   input int n, input int oa);
    exp_t e;
    int nn;
    nn = (n > MI) ? MI : n;
    e.x = x0; e.y = y0; e.z = z0;
    e.iter = 0; e.ovf = 1'b0;
    for (int k = 0; k < nn; k++) begin
      cstep(sys, mode, sys ? k : hyp_seq[k], e.x, e.y, e.z);
      e.iter++;
      if (e.iter == oa) begin
        e.ovf = 1'b1;
        break;
      end
    end
    e.lat = (e.ovf && e.iter < nn) ? e.iter + 3 : nn + 2;
    return e;
  endfunction

  task automatic run_op(input logic sys, input logic mode,
                        input logic signed [W-1:0] x,
                        input logic signed [W-1:0] y,
                        input logic signed [W-1:0] z,
                        input int n, input int oa, input int hold,
                        output logic signed [W-1:0] ox,
                        output logic signed [W-1:0] oy,
                        output logic signed [W-1:0] oz);
    exp_t g;
    longint t0;
    bit seen;
    ovf_at = oa;
    sb.push_back(ref_run(sys, mode, x, y, z, n, oa));
    @(negedge clk);
    shq.delete();
    cur_sys = sys; cur_mode = mode;
    req_x = x; req_y = y; req_z = z;
    req_system = sys; req_mode = mode;
    req_num_iter = NW'(n);
    req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("core_load", core_load, 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    g = sb.pop_front();
    chk("rsp_seen", seen, 1);
    chk("latency", cyc - t0, g.lat);
    chk("rsp_x", $signed(rsp_x), g.x);
    chk("rsp_y", $signed(rsp_y), g.y);
    chk("rsp_z", $signed(rsp_z), g.z);
    chk("rsp_iter", rsp_iter, g.iter);
    chk("rsp_ovf", rsp_overflow, g.ovf);
    chk("nsteps", shq.size(), g.iter);
    for (int k = 0; k < shq.size() && k < g.iter; k++)
      chk("shift", shq[k], sys ? k : hyp_seq[k]);
    ox = $signed(rsp_x); oy = $signed(rsp_y); oz = $signed(rsp_z);
    if (hold > 0) begin
      req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_x", $signed(rsp_x), g.x);
        chk("bp_y", $signed(rsp_y), g.y);
        chk("bp_z", $signed(rsp_z), g.z);
        chk("bp_iter", rsp_iter, g.iter);
        chk("bp_ready", req_ready, 0);
        chk("bp_load", core_load, 0);
        chk("bp_step", core_step, 0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_no_load", core_load, 0);
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time bound exceeded");
    $fatal(1);
  end

  initial begin
    logic signed [W-1:0] ox, oy, oz;
    logic signed [W-1:0] kx, z45, one28, zh;
    real rx, ry, rz, hz;
    bit found;

    for (int s = 1; hyp_seq.size() < MI; s++) begin
      hyp_seq.push_back(s);
      if (s == 4 || s == 13) hyp_seq.push_back(s);
    end

    #1;
    chk("rst_outs", {busy, core_load, core_step, rsp_valid, rsp_overflow,
                     core_system, core_mode}, 0);
    chk("rst_shift", core_shift, 0);
    chk("rst_iter", rsp_iter, 0);
    chk("rst_rsp", rsp_x | rsp_y | rsp_z, 0);
    chk("rst_core_in", core_x_in | core_y_in | core_z_in, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);
    chk("rel_busy", busy, 0);

    kx    = $rtoi(0.6072529350092496 * (2.0 ** 31));
    z45   = 32'sh2000_0000;
    one28 = 32'sh1000_0000;

    run_op(1'b1, 1'b1, kx, 0, z45, 10, 0, 0, ox, oy, oz);
    rx = $itor(ox) / (2.0 ** 31);
    ry = $itor(oy) / (2.0 ** 31);
    rz = $itor(oz) * 360.0 / 4294967296.0;
    chk("circ_x_tol", (rx > 0.70710678 - 2e-3 && rx < 0.70710678 + 2e-3), 1);
    chk("circ_y_tol", (ry > 0.70710678 - 2e-3 && ry < 0.70710678 + 2e-3), 1);
    chk("circ_z_tol", (rz > -0.5 && rz < 0.5), 1);

    run_op(1'b0, 1'b0, one28, one28 >>> 1, 0, 10, 0, 0, ox, oy, oz);
    ry = $itor(oy) / (2.0 ** 28);
    rz = $itor(oz) * 360.0 / 4294967296.0;
    hz = $atanh(0.5) * 180.0 / PI;
    chk("hyp_z_tol", (rz > hz - 0.5 && rz < hz + 0.5), 1);
    chk("hyp_y_tol", (ry > -1e-2 && ry < 1e-2), 1);

    run_op(1'b1, 1'b1, kx, 0, z45, 10, 4, 0, ox, oy, oz);
    run_op(1'b1, 1'b1, 32'sh1234_5678, -32'sd777, 32'sh0abc_def0,
           0, 0, 0, ox, oy, oz);
    run_op(1'b1, 1'b1, kx, 0, -z45, 31, 0, 0, ox, oy, oz);

    zh = $rtoi(0.3 / (2.0 * PI) * 4294967296.0);
    run_op(1'b0, 1'b1, one28, 0, zh, 31, 0, 5, ox, oy, oz);

    ovf_at = 0;
    @(negedge clk);
    shq.delete();
    cur_sys = 1'b1; cur_mode = 1'b1;
    req_x = kx; req_y = '0; req_z = z45;
    req_system = 1'b1; req_mode = 1'b1; req_num_iter = 5'd10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (core_step && core_shift == 5'd3) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_step3", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {busy, core_load, core_step, rsp_valid, rsp_overflow,
                      core_system, core_mode}, 0);
    chk("arst_shift", core_shift, 0);
    chk("arst_iter", rsp_iter, 0);
    chk("arst_rsp", rsp_x | rsp_y | rsp_z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arel_req_ready", req_ready, 1);
    chk("arel_busy", busy, 0);
    chk("arel_rsp_valid", rsp_valid, 0);

    run_op(1'b1, 1'b1, kx, 0, z45, 10, 0, 0, ox, oy, oz);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
